// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, RUN/HALTED fetch FSM
// and a saturating count of instructions loaded into IF/ID.
module if_stage #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
   parameter logic [4:0]        HALT_OP  = 5'b00001
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_q,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic               if_id_valid,
   output logic               halted,
   output logic [15:0]        fetch_count
);

   typedef enum logic {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t               r_state,       w_state_nxt;
   logic [ADDR_W-1:0]    r_pc,          w_pc_nxt;
   logic [INSTR_W-1:0]   r_instr,       w_instr_nxt;
   logic [ADDR_W-1:0]    r_if_id_pc,    w_if_id_pc_nxt;
   logic                 r_valid,       w_valid_nxt;
   logic [15:0]          r_fetch_count, w_fetch_count_nxt;
   logic                 w_is_halt;

   assign w_is_halt = (imem_q[INSTR_W-1 -: 5] == HALT_OP);

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_instr_nxt       = r_instr;
      w_if_id_pc_nxt    = r_if_id_pc;
      w_valid_nxt       = r_valid;
      w_fetch_count_nxt = r_fetch_count;

      if (branch_taken) begin
         w_state_nxt = S_RUN;
         w_pc_nxt    = branch_target;
         w_valid_nxt = 1'b0;
      end else if (!stall) begin
         case (r_state)
            S_RUN: begin
               w_instr_nxt    = imem_q;
               w_if_id_pc_nxt = r_pc;
               w_valid_nxt    = 1'b1;
               if (r_fetch_count != 16'hFFFF)
                  w_fetch_count_nxt = r_fetch_count + 16'd1;
               // A HALT parks the PC on its own address so a later redirect is the only way out.
               if (w_is_halt)
                  w_state_nxt = S_HALTED;
               else
                  w_pc_nxt = r_pc + ADDR_W'(1);
            end
            S_HALTED: w_valid_nxt = 1'b0;
            default:  w_state_nxt = S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_RUN;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_if_id_pc    <= '0;
         r_valid       <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values computed above.
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_if_id_pc    <= w_if_id_pc_nxt;
         r_valid       <= w_valid_nxt;
         r_fetch_count <= w_fetch_count_nxt;
      end
   end

   assign imem_addr   = r_pc;
   assign if_id_instr = r_instr;
   assign if_id_pc    = r_if_id_pc;
   assign if_id_valid = r_valid;
   assign halted      = (r_state == S_HALTED);
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written halt/reset
// sequences, randomized run against a behavioural model, and count saturation.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic [7:0]  imem_addr;
   logic [15:0] imem_q;
   logic [15:0] if_id_instr;
   logic [7:0]  if_id_pc;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_count;

   logic [15:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_q = mem[imem_addr];

   if_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_addr    (imem_addr),
      .imem_q       (imem_q),
      .if_id_instr  (if_id_instr),
      .if_id_pc     (if_id_pc),
      .if_id_valid  (if_id_valid),
      .halted       (halted),
      .fetch_count  (fetch_count)
   );

   typedef struct {
      logic        s;
      logic        b;
      logic [7:0]  tgt;
      logic [7:0]  e_addr;
      logic [7:0]  e_pc;
      logic [15:0] e_instr;
      logic        e_valid;
      logic        e_halted;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs [14];

   // Behavioural model state
   int m_pc, m_ipc, m_instr, m_valid, m_halted, m_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] a, input logic [7:0] p,
                            input logic [15:0] ins, input logic v, input logic h,
                            input logic [15:0] c);
      check({tag, "_addr"},   {24'd0, imem_addr},   {24'd0, a});
      check({tag, "_pc"},     {24'd0, if_id_pc},    {24'd0, p});
      check({tag, "_instr"},  {16'd0, if_id_instr}, {16'd0, ins});
      check({tag, "_valid"},  {31'd0, if_id_valid}, {31'd0, v});
      check({tag, "_halted"}, {31'd0, halted},      {31'd0, h});
      check({tag, "_count"},  {16'd0, fetch_count}, {16'd0, c});
   endtask

   task automatic model_reset();
      m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_count = 0;
   endtask

   // Applies the fetch rules to one clock edge using the inputs currently driven.
   task automatic model_step();
      if (branch_taken) begin
         m_pc = branch_target; m_valid = 0; m_halted = 0;
      end else if (!stall) begin
         if (m_halted == 0) begin
            m_instr = mem[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            if (m_count < 65535) m_count++;
            if ((m_instr >> 11) == 1) m_halted = 1;
            else m_pc = (m_pc + 1) % 256;
         end else begin
            m_valid = 0;
         end
      end
   endtask

   // Entered and left at a falling edge.
   task automatic step(input logic s, input logic b, input logic [7:0] t);
      stall = s; branch_taken = b; branch_target = t;
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
      #2;
      check_all(tag, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic fill_seq_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
   endtask

   initial begin
      rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
      fill_seq_mem();
      @(negedge clk);
      do_reset("rst0");

      //           s  b  tgt    addr   pc     instr     v  h  cnt
      vecs[0]  = '{0, 0, 8'h00, 8'h01, 8'h00, 16'h1000, 1, 0, 16'd1};
      vecs[1]  = '{0, 0, 8'h00, 8'h02, 8'h01, 16'h1001, 1, 0, 16'd2};
      vecs[2]  = '{0, 0, 8'h00, 8'h03, 8'h02, 16'h1002, 1, 0, 16'd3};
      vecs[3]  = '{0, 0, 8'h00, 8'h04, 8'h03, 16'h1003, 1, 0, 16'd4};
      vecs[4]  = '{0, 0, 8'h00, 8'h05, 8'h04, 16'h1004, 1, 0, 16'd5};
      vecs[5]  = '{1, 0, 8'h00, 8'h05, 8'h04, 16'h1004, 1, 0, 16'd5};
      vecs[6]  = '{1, 0, 8'h00, 8'h05, 8'h04, 16'h1004, 1, 0, 16'd5};
      vecs[7]  = '{1, 0, 8'h00, 8'h05, 8'h04, 16'h1004, 1, 0, 16'd5};
      vecs[8]  = '{0, 0, 8'h00, 8'h06, 8'h05, 16'h1005, 1, 0, 16'd6};
      vecs[9]  = '{1, 1, 8'h40, 8'h40, 8'h05, 16'h1005, 0, 0, 16'd6};
      vecs[10] = '{0, 0, 8'h00, 8'h41, 8'h40, 16'h1040, 1, 0, 16'd7};
      vecs[11] = '{0, 1, 8'hFE, 8'hFE, 8'h40, 16'h1040, 0, 0, 16'd7};
      vecs[12] = '{0, 0, 8'h00, 8'hFF, 8'hFE, 16'h10FE, 1, 0, 16'd8};
      vecs[13] = '{0, 0, 8'h00, 8'h00, 8'hFF, 16'h10FF, 1, 0, 16'd9};

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].s, vecs[i].b, vecs[i].tgt);
         check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr,
                   vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_cnt);
      end

      // Halt at address 3, stall while halted, then redirect out.
      mem[3] = 16'h0800;
      step(0, 1, 8'h00);
      check_all("h_br0", 8'h00, 8'hFF, 16'h10FF, 0, 0, 16'd9);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      check_all("h_pre", 8'h03, 8'h02, 16'h1002, 1, 0, 16'd12);
      step(0, 0, 8'h00);
      check_all("h_load", 8'h03, 8'h03, 16'h0800, 1, 1, 16'd13);
      step(1, 0, 8'h00);
      check_all("h_stall", 8'h03, 8'h03, 16'h0800, 1, 1, 16'd13);
      step(0, 0, 8'h00);
      check_all("h_idle", 8'h03, 8'h03, 16'h0800, 0, 1, 16'd13);
      step(0, 0, 8'h00);
      check_all("h_idle2", 8'h03, 8'h03, 16'h0800, 0, 1, 16'd13);
      step(0, 1, 8'h10);
      check_all("h_br", 8'h10, 8'h03, 16'h0800, 0, 0, 16'd13);
      step(0, 0, 8'h00);
      check_all("h_resume", 8'h11, 8'h10, 16'h1010, 1, 0, 16'd14);

      // Asynchronous reset while HALTED with seven fetches counted.
      fill_seq_mem();
      mem[6] = 16'h0800;
      do_reset("rst1");
      for (int i = 0; i < 7; i++) step(0, 0, 8'h00);
      check_all("ar_pre", 8'h06, 8'h06, 16'h0800, 1, 1, 16'd7);
      stall = 1'b0; branch_taken = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_all("ar_async", 8'h00, 8'h00, 16'h0000, 0, 0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      mem[6] = 16'h1006;
      step(0, 0, 8'h00);
      check_all("ar_first", 8'h01, 8'h00, 16'h1000, 1, 0, 16'd1);

      // Randomized run against the model, memory sprinkled with HALTs.
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         if ($urandom_range(0, 15) == 0) mem[i][15:11] = 5'b00001;
         else if (mem[i][15:11] == 5'b00001) mem[i][15:11] = 5'b00011;
      end
      do_reset("rst2");
      for (int i = 0; i < 3000; i++) begin
         step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 9) == 0),
              8'($urandom));
         check_all("rand", 8'(m_pc), 8'(m_ipc), 16'(m_instr), m_valid[0], m_halted[0],
                   16'(m_count));
      end

      // fetch_count saturation.
      fill_seq_mem();
      do_reset("rst3");
      repeat (65534) step(0, 0, 8'h00);
      check("sat_fffe", {16'd0, fetch_count}, 32'h0000FFFE);
      step(0, 0, 8'h00);
      check("sat_ffff", {16'd0, fetch_count}, 32'h0000FFFF);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      check("sat_hold", {16'd0, fetch_count}, 32'h0000FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
